// File: rtl/lane_collector_26.sv
`default_nettype none
// ============================================================================
//  Module   : lane_collector_26
//  Purpose  : Gathers LANES serial DW-bit words into one packed bus beat,
//             lane 0 (first word of a frame) at the LSBs.
//  Revision : 1.0  initial release
// ============================================================================
module lane_collector_26 #(
    parameter int DW    = 16,
    parameter int LANES = 26
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DW-1:0]         din,
    input  logic                  din_valid,
    input  logic                  din_sof,
    output logic                  din_ready,
    output logic [LANES*DW-1:0]   com_bus_out,
    output logic                  bus_valid,
    input  logic                  bus_ready,
    output logic                  err_resync,
    output logic [15:0]           frame_cnt
);

    localparam int            c_cnt_w    = $clog2(LANES);
    localparam logic [c_cnt_w-1:0] c_last_lane = c_cnt_w'(LANES - 1);

    logic [c_cnt_w-1:0]  r_cnt;
    logic [LANES*DW-1:0] r_buf;
    logic [LANES*DW-1:0] r_com;
    logic                r_bus_valid;
    logic                r_err;
    logic [15:0]         r_frame_cnt;

    logic                w_accept;
    logic                w_drain;
    logic                w_complete;
    logic                w_resync;
    logic [c_cnt_w-1:0]  w_lane;
    logic [LANES*DW-1:0] w_frame;

    // Only the closing word can be refused: everything earlier lands in the buffer.
    assign din_ready  = !((r_cnt == c_last_lane) && r_bus_valid && !bus_ready);
    assign w_accept   = din_valid && din_ready;
    assign w_drain    = r_bus_valid && bus_ready;
    assign w_lane     = din_sof ? '0 : r_cnt;
    assign w_complete = w_accept && (w_lane == c_last_lane);
    assign w_resync   = w_accept && din_sof && (r_cnt != '0);
    // Closing word bypasses the buffer so the frame is published on its own edge.
    assign w_frame    = {din, r_buf[(LANES-1)*DW-1:0]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
            r_buf <= '0;
        end else if (w_accept) begin
            for (int i = 0; i < LANES; i++) begin
                if (w_lane == c_cnt_w'(i)) begin
                    r_buf[i*DW +: DW] <= din;
                end
            end
            r_cnt <= w_complete ? '0 : w_lane + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_com       <= '0;
            r_bus_valid <= 1'b0;
            r_err       <= 1'b0;
            r_frame_cnt <= '0;
        end else begin
            r_err <= w_resync;
            if (w_complete) begin
                r_com       <= w_frame;
                r_bus_valid <= 1'b1;
                r_frame_cnt <= r_frame_cnt + 16'd1;
            end else if (w_drain) begin
                r_bus_valid <= 1'b0;
            end
        end
    end

    assign com_bus_out = r_com;
    assign bus_valid   = r_bus_valid;
    assign err_resync  = r_err;
    assign frame_cnt   = r_frame_cnt;

endmodule
`default_nettype wire
